text_scanout_controller: RTL and testbench
==========================================

# text_scanout_controller

Sequencing controller for the GPU's text-mode display path. Generates 640x480@60 VGA timing from CLOCK_50 and walks an 80x24 grid of 8x20 character cells. For each pixel it reads the character code from the text buffer RAM, drives the font ROM's character/cell lookup, and registers the returned pixel bit as colour. Sync and blanking are delayed to match, and an optional blinking underline cursor is overlaid.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line; H_FP 16, H_SYNC 96, H_BP 48 (line total 800)
- V_ACTIVE, 480, visible lines; V_FP 10, V_SYNC 2, V_BP 33 (frame total 525)
- COLS, 80, character columns; ROWS, 24, character rows; CELL_H, 20, pixel rows per cell (cell width fixed at 8)
- FG_COLOR, 12'hFFF, {R,G,B} 4 bits each, for pixel bit 1; BG_COLOR, 12'h000, for pixel bit 0
- BLINK_FRAMES, 32, frames per cursor blink phase

Ports:
- CLOCK_50  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- text_addr  out  11  text buffer read address = row*COLS + col
- text_data  in  8  character code; synchronous RAM, valid one clock after text_addr
- font_character  out  8  to font ROM character; combinational pass-through of text_data
- font_cell_x  out  3  to font ROM cell column
- font_cell_y  out  5  to font ROM cell row (0..19)
- font_pixel  in  1  font ROM pixel_value; valid one clock after sampling
- cursor_en  in  1  enable cursor overlay
- cursor_col  in  7  cursor column; cursor_row  in  5  cursor row
- vga_r, vga_g, vga_b  out  4 each  colour
- vga_hs, vga_vs  out  1  syncs, active low
- vga_de  out  1  data enable (active area)
- frame_start  out  1  one-clock pulse when counters wrap to (0,0)

## Operation
- pix_en: toggle register, reset 0; counters advance only on edges where pix_en=1 (25 MHz pixel rate).
- h_cnt 0..799 wraps to 0 and increments v_cnt. v_cnt 0..524 wraps to 0 and produces frame_start high for the following clock.
- Cell tracking without dividers: col = h_cnt[9:3]. cell_y counts 0..19 then resets to 0 and increments row. cell_y and row clear at v_cnt wrap and are held during vertical blanking.
- text_addr = row*80 + col, built as (row<<6)+(row<<4)+col and registered from the counter state. Max 1919. Forced to 0 outside the active area.
- font_cell_x = h_cnt[2:0]; font_cell_y = cell_y; both stable for the full two-clock pixel period.
- Active area: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE. hs_raw is low when h_cnt is in [656,751]. vs_raw is low when v_cnt is in [490,491].
- Cursor hit: cursor_en, row==cursor_row, col==cursor_col, cell_y in {18,19}, and blink phase=1. A hit inverts the pixel bit.
- Blink: a frame counter counts to BLINK_FRAMES-1, then toggles the blink phase. Both reset to 0.
- Colour = FG_COLOR when the final bit is 1, else BG_COLOR. Outside the active area, colour is forced to 0.

## Timing
- Pipeline, in CLOCK_50 edges. Counter state is set at E0 (pix_en=1). text_addr is registered at E0. text_data is valid after E1. The font ROM samples at E2, and font_pixel is valid after E2. Outputs are registered at E3 (pix_en=0 edges) and held for 2 clocks.
- Total latency from counter state to pins: 3 clocks. vga_hs, vga_vs, vga_de and the cursor-hit bit pass through an equal-length delay line, so all outputs stay aligned.
- Reset values: pix_en 0, h_cnt 0, v_cnt 0, cell_y 0, row 0, text_addr 0, vga_hs 1, vga_vs 1, vga_de 0, rgb 0, frame_start 0, blink phase 0, frame counter 0. Delay lines clear to the inactive values.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). The first valid pixel reappears 3 clocks after the first pix_en=1 edge following RESET_N rise.
- Changes to cursor_col, cursor_row and cursor_en take effect at the next pixel period. No glitch beyond one pixel.

## Test plan
- Reset release, 1 frame -> hs period 1600 clocks, low for 192; vs period 840000 clocks, low for 2 lines; de high for 640 px x 480 lines; frame_start once per 840000 clocks.
- Text RAM model with addr 81 = 8'h41; font model returns 1 only for char 8'h41 -> colour FG on h 8..15, v 20..39 only; text_addr=81 observed during those pixels.
- Last cell (col 79, row 23) -> text_addr=1919 at h 632..639, v 460..479; addr 0 outside the active area.
- Cursor at (3,2) enabled, blank text -> FG on h 24..31, v 58..59 for 32 frames, then BG for 32 frames.
- Latency check: single-pixel font pattern at cell_x=0 -> vga_r/g/b change exactly 3 clocks after the counter edge, coincident with vga_de.
- RESET_N asserted mid-line -> outputs go to reset values without a clock edge; timing resumes from (0,0).

Source files
------------

// File: rtl/text_scanout_controller.sv
// Text-mode VGA scanout: raster counters, 8xCELL_H cell walker, text/font fetch
// pipeline and blinking underline cursor, all outputs aligned to a 3-clock latency.
module text_scanout_controller #(
  parameter int          H_ACTIVE     = 640,
  parameter int          H_FP         = 16,
  parameter int          H_SYNC       = 96,
  parameter int          H_BP         = 48,
  parameter int          V_ACTIVE     = 480,
  parameter int          V_FP         = 10,
  parameter int          V_SYNC       = 2,
  parameter int          V_BP         = 33,
  parameter int          COLS         = 80,
  parameter int          ROWS         = 24,
  parameter int          CELL_H       = 20,
  parameter logic [11:0] FG_COLOR     = 12'hFFF,
  parameter logic [11:0] BG_COLOR     = 12'h000,
  parameter int          BLINK_FRAMES = 32
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  output logic [10:0] text_addr,
  input  logic [7:0]  text_data,
  output logic [7:0]  font_character,
  output logic [2:0]  font_cell_x,
  output logic [4:0]  font_cell_y,
  input  logic        font_pixel,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic        frame_start
);

  localparam logic [9:0]  H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  V_ACT_M1 = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [4:0]  CY_LAST  = 5'(CELL_H - 1);
  localparam logic [4:0]  CY_UL    = 5'(CELL_H - 2);
  localparam logic [4:0]  ROW_LAST = 5'(ROWS - 1);
  localparam logic [6:0]  COL_LIM  = 7'(COLS);
  localparam logic [15:0] BF_LAST  = 16'(BLINK_FRAMES - 1);

  logic        pix_en;
  logic [9:0]  h_cnt, v_cnt, h_nxt, v_nxt;
  logic [4:0]  cell_y, cell_y_nxt, row, row_nxt;
  logic        frame_wrap;
  logic        active_nxt;
  logic [10:0] addr_nxt;
  logic [15:0] blink_cnt;
  logic        blink_ph;
  logic        de_raw, hs_raw, vs_raw, hit_raw;
  logic        s1_de, s1_hs, s1_vs, s1_hit;
  logic [11:0] rgb;

  always_comb begin
    h_nxt      = h_cnt + 10'd1;
    v_nxt      = v_cnt;
    cell_y_nxt = cell_y;
    row_nxt    = row;
    frame_wrap = 1'b0;
    if (h_cnt == H_LAST) begin
      h_nxt = '0;
      if (v_cnt == V_LAST) begin
        v_nxt      = '0;
        cell_y_nxt = '0;
        row_nxt    = '0;
        frame_wrap = 1'b1;
      end else begin
        v_nxt = v_cnt + 10'd1;
        // cell position only moves while the next line is still visible
        if (v_cnt < V_ACT_M1) begin
          if (cell_y == CY_LAST) begin
            cell_y_nxt = '0;
            row_nxt    = (row == ROW_LAST) ? row : row + 5'd1;
          end else begin
            cell_y_nxt = cell_y + 5'd1;
          end
        end
      end
    end
  end

  // address is computed from the next counter state so RAM data lands one clock later
  always_comb begin
    active_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    addr_nxt   = '0;
    if (active_nxt)
      addr_nxt = {row_nxt, 6'b0} + {2'b0, row_nxt, 4'b0} + {4'b0, h_nxt[9:3]};
  end

  always_comb begin
    de_raw  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_raw  = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    vs_raw  = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
    hit_raw = cursor_en && blink_ph && (row == cursor_row) &&
              (h_cnt[9:3] == cursor_col) && (h_cnt[9:3] < COL_LIM) &&
              ((cell_y == CY_UL) || (cell_y == CY_LAST));
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      pix_en      <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      cell_y      <= '0;
      row         <= '0;
      text_addr   <= '0;
      frame_start <= 1'b0;
      blink_cnt   <= '0;
      blink_ph    <= 1'b0;
      s1_de       <= 1'b0;
      s1_hs       <= 1'b1;
      s1_vs       <= 1'b1;
      s1_hit      <= 1'b0;
      vga_de      <= 1'b0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      rgb         <= '0;
    end else begin
      pix_en      <= ~pix_en;
      frame_start <= pix_en & frame_wrap;
      if (pix_en) begin
        h_cnt     <= h_nxt;
        v_cnt     <= v_nxt;
        cell_y    <= cell_y_nxt;
        row       <= row_nxt;
        text_addr <= addr_nxt;
        if (frame_wrap) begin
          if (blink_cnt == BF_LAST) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
          end else begin
            blink_cnt <= blink_cnt + 16'd1;
          end
        end
      end else begin
        // mid-period edge: capture this pixel's controls, emit the previous pixel
        s1_de  <= de_raw;
        s1_hs  <= hs_raw;
        s1_vs  <= vs_raw;
        s1_hit <= hit_raw;
        vga_de <= s1_de;
        vga_hs <= s1_hs;
        vga_vs <= s1_vs;
        if (!s1_de)
          rgb <= '0;
        else if (font_pixel ^ s1_hit)
          rgb <= FG_COLOR;
        else
          rgb <= BG_COLOR;
      end
    end
  end

  assign font_character = text_data;
  assign font_cell_x    = h_cnt[2:0];
  assign font_cell_y    = cell_y;
  assign vga_r          = rgb[11:8];
  assign vga_g          = rgb[7:4];
  assign vga_b          = rgb[3:0];

endmodule

// File: tb/tb_text_scanout_controller.sv
// Directed bench for text_scanout_controller on a shrunken raster (80x66 pixel
// frame, 2-frame blink) with behavioural text RAM and font ROM models.
module tb_text_scanout_controller;

  localparam int unsigned HT = 80;    // 64 + 4 + 8 + 4
  localparam int unsigned FT = 5280;  // 80 * 66

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] text_addr;
  logic [7:0]  text_data = 8'h00;
  logic [7:0]  font_character;
  logic [2:0]  font_cell_x;
  logic [4:0]  font_cell_y;
  logic        font_pixel = 1'b0;
  logic        cursor_en = 1'b0;
  logic [6:0]  cursor_col = 7'd0;
  logic [4:0]  cursor_row = 5'd0;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_de, frame_start;
  logic [11:0] rgb;

  int unsigned edge_cnt = 0;
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  mem [0:2047];

  assign rgb = {vga_r, vga_g, vga_b};

  text_scanout_controller #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(60), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .COLS(80), .ROWS(3), .CELL_H(20),
    .FG_COLOR(12'hFFF), .BG_COLOR(12'h000), .BLINK_FRAMES(2)
  ) dut (
    .CLOCK_50(clk), .RESET_N(rst_n),
    .text_addr(text_addr), .text_data(text_data),
    .font_character(font_character), .font_cell_x(font_cell_x),
    .font_cell_y(font_cell_y), .font_pixel(font_pixel),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
    .frame_start(frame_start)
  );

  always #10 clk = ~clk;

  // edges since reset release; edge 1 is the first posedge with RESET_N high
  always @(posedge clk) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  always @(posedge clk) text_data <= mem[text_addr];

  // 'A' lights the whole cell, 'B' only its first pixel column
  always @(posedge clk)
    font_pixel <= (font_character == 8'h41) ||
                  ((font_character == 8'h42) && (font_cell_x == 3'd0) && (font_cell_y < 5'd20));

  initial begin
    #2_000_000;
    $display("FAIL timeout edge_cnt=%0d", edge_cnt);
    $fatal(1, "bench timeout");
  end

  function automatic int unsigned out_edge(input int unsigned f, input int unsigned v, input int unsigned h);
    return 3 + 2 * (f * FT + v * HT + h);
  endfunction

  function automatic int unsigned addr_edge(input int unsigned f, input int unsigned v, input int unsigned h);
    return 2 * (f * FT + v * HT + h);
  endfunction

  task automatic wait_edge(input int unsigned n);
    while (edge_cnt < n) @(negedge clk);
    if (edge_cnt != n) begin
      failures++;
      $display("FAIL sched observed_edge=%0d expected_edge=%0d", edge_cnt, n);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h20;
    mem[2]   = 8'h42;
    mem[81]  = 8'h41;
    mem[165] = 8'h42;
    cursor_en  = 1'b1;
    cursor_col = 7'd3;
    cursor_row = 5'd2;

    #25;
    check("rst_hs", 32'(vga_hs), 32'd1);
    check("rst_vs", 32'(vga_vs), 32'd1);
    check("rst_de", 32'(vga_de), 32'd0);
    check("rst_rgb", 32'(rgb), 32'h000);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_addr", 32'(text_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // frame 0: latency, addressing, syncs, text cell
    wait_edge(addr_edge(0, 0, 16));  check("addr_b", 32'(text_addr), 32'd2);
    wait_edge(out_edge(0, 0, 15));   check("lat_pre", 32'(rgb), 32'h000);
    wait_edge(out_edge(0, 0, 16));   check("lat_on", 32'(rgb), 32'hFFF);
                                     check("lat_de", 32'(vga_de), 32'd1);
    wait_edge(out_edge(0, 0, 16) + 1); check("lat_hold", 32'(rgb), 32'hFFF);
    wait_edge(out_edge(0, 0, 17));   check("lat_off", 32'(rgb), 32'h000);
    wait_edge(out_edge(0, 0, 63));   check("de_last", 32'(vga_de), 32'd1);
    wait_edge(out_edge(0, 0, 64));   check("de_end", 32'(vga_de), 32'd0);
    wait_edge(out_edge(0, 0, 67));   check("hs_pre", 32'(vga_hs), 32'd1);
    wait_edge(out_edge(0, 0, 68));   check("hs_lo0", 32'(vga_hs), 32'd0);
    wait_edge(addr_edge(0, 0, 70));  check("addr_hblank", 32'(text_addr), 32'd0);
    wait_edge(out_edge(0, 0, 75));   check("hs_lo1", 32'(vga_hs), 32'd0);
    wait_edge(out_edge(0, 0, 76));   check("hs_post", 32'(vga_hs), 32'd1);
    wait_edge(out_edge(0, 19, 8));   check("a_above", 32'(rgb), 32'h000);
    wait_edge(addr_edge(0, 20, 8));  check("addr_81", 32'(text_addr), 32'd81);
    wait_edge(out_edge(0, 20, 7));   check("a_left", 32'(rgb), 32'h000);
    wait_edge(out_edge(0, 20, 8));   check("a_first", 32'(rgb), 32'hFFF);
    wait_edge(out_edge(0, 39, 15));  check("a_last", 32'(rgb), 32'hFFF);
    wait_edge(out_edge(0, 40, 8));   check("a_below", 32'(rgb), 32'h000);
    wait_edge(out_edge(0, 59, 0));   check("de_vlast", 32'(vga_de), 32'd1);
    wait_edge(addr_edge(0, 59, 63)); check("addr_lastcell", 32'(text_addr), 32'd167);
    wait_edge(out_edge(0, 60, 0));   check("de_vend", 32'(vga_de), 32'd0);
    wait_edge(out_edge(0, 61, 0));   check("vs_pre", 32'(vga_vs), 32'd1);
    wait_edge(addr_edge(0, 61, 8));  check("addr_vblank", 32'(text_addr), 32'd0);
    wait_edge(out_edge(0, 62, 0));   check("vs_lo0", 32'(vga_vs), 32'd0);
    wait_edge(out_edge(0, 63, 79));  check("vs_lo1", 32'(vga_vs), 32'd0);
    wait_edge(out_edge(0, 64, 0));   check("vs_post", 32'(vga_vs), 32'd1);
    wait_edge(2 * FT - 1);           check("fs_pre", 32'(frame_start), 32'd0);
    wait_edge(2 * FT);               check("fs_pulse", 32'(frame_start), 32'd1);
    wait_edge(2 * FT + 1);           check("fs_post", 32'(frame_start), 32'd0);

    // cursor blink: off in frames 0-1, on in 2-3, off again in 4
    wait_edge(out_edge(1, 58, 24));  check("cur_f1_off", 32'(rgb), 32'h000);
    wait_edge(out_edge(2, 57, 24));  check("cur_f2_above", 32'(rgb), 32'h000);
    wait_edge(out_edge(2, 58, 24));  check("cur_f2_on0", 32'(rgb), 32'hFFF);
    wait_edge(out_edge(2, 58, 32));  check("cur_f2_right", 32'(rgb), 32'h000);
    wait_edge(out_edge(2, 59, 31));  check("cur_f2_on1", 32'(rgb), 32'hFFF);
    wait_edge(out_edge(4, 58, 24));  check("cur_f4_off", 32'(rgb), 32'h000);
    wait_edge(out_edge(4, 58, 40));  check("b_row2", 32'(rgb), 32'hFFF);

    // asynchronous reset mid-line, then timing restarts from (0,0)
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rgb", 32'(rgb), 32'h000);
    check("mid_de", 32'(vga_de), 32'd0);
    check("mid_hs", 32'(vga_hs), 32'd1);
    check("mid_vs", 32'(vga_vs), 32'd1);
    check("mid_addr", 32'(text_addr), 32'd0);
    check("mid_fs", 32'(frame_start), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_edge(out_edge(0, 0, 15));   check("re_pre", 32'(rgb), 32'h000);
    wait_edge(out_edge(0, 0, 16));   check("re_on", 32'(rgb), 32'hFFF);
    wait_edge(addr_edge(0, 20, 8));  check("re_addr_81", 32'(text_addr), 32'd81);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
